// File: rtl/rsa_modexp_core_if.sv
// rsa_modexp_core_if
// Request/response bundle for the RSA modular-exponentiation engine.
//   start    - request strobe, taken only while the engine is idle
//   message  - base m, WIDTH bits
//   exp_key  - exponent e, WIDTH bits
//   n        - modulus, WIDTH bits
//   c        - result m^e mod n, held until the next completion
//   busy     - engine is working on an accepted request
//   done     - one-cycle completion pulse
//   err      - qualifies done when the operands were illegal
// Modports: master drives the request side, slave is the engine.
// WIDTH must match the WIDTH of the rsa_modexp_core it is bound to.
interface rsa_modexp_core_if #(
    parameter int WIDTH = 128
);
    logic             start;
    logic [WIDTH-1:0] message;
    logic [WIDTH-1:0] exp_key;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] c;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, message, exp_key, n,
        input  c, busy, done, err
    );

    modport slave (
        input  start, message, exp_key, n,
        output c, busy, done, err
    );
endinterface

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core
// Computes c = message^exp_key mod n with right-to-left square-and-multiply.
// Each exponent bit costs one MUL phase (WIDTH cycles of bit-serial
// interleaved modular multiplication, result*base and base*base in parallel)
// followed by one STEP cycle that folds the products back in.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; aborts any operation
//   bus   - rsa_modexp_core_if.slave (start/message/exp_key/n in,
//           c/busy/done/err out)
// Build option:
//   RSA_CONST_TIME_EN - when defined, always processes WIDTH exponent bits so
//   the latency does not depend on the exponent; when undefined, stops as
//   soon as the remaining exponent is zero.
module rsa_modexp_core #(
    parameter int WIDTH = 128
) (
    input  logic               clk,
    input  logic               reset,
    rsa_modexp_core_if.slave   bus
);

    localparam int JW = $clog2(WIDTH);
    localparam int IW = $clog2(WIDTH + 1);

`ifdef RSA_CONST_TIME_EN
    localparam bit EARLY_EXIT = 1'b0;
`else
    localparam bit EARLY_EXIT = 1'b1;
`endif

    typedef enum logic [1:0] {IDLE, MUL, STEP, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH:0]   acc_r_q, acc_r_d;
    logic [WIDTH:0]   acc_b_q, acc_b_d;
    logic [JW-1:0]    bit_idx_q, bit_idx_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             err_q, err_d;

    // One step of interleaved modular multiplication. acc < n on entry, so
    // 2*acc and acc + a both stay below 2n and fit in WIDTH+1 bits; a single
    // conditional subtraction restores acc < n after each.
    function automatic logic [WIDTH:0] mod_mul_step(
        input logic [WIDTH:0]   acc,
        input logic [WIDTH-1:0] a,
        input logic             b_bit,
        input logic [WIDTH-1:0] modulus
    );
        logic [WIDTH:0] t;
        logic [WIDTH:0] nx;
        nx = {1'b0, modulus};
        t  = {acc[WIDTH-1:0], 1'b0};
        if (t >= nx) t = t - nx;
        if (b_bit) begin
            t = t + {1'b0, a};
            if (t >= nx) t = t - nx;
        end
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            e_q       <= '0;
            n_q       <= '0;
            result_q  <= '0;
            base_q    <= '0;
            acc_r_q   <= '0;
            acc_b_q   <= '0;
            bit_idx_q <= '0;
            iter_q    <= '0;
            c_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            e_q       <= e_d;
            n_q       <= n_d;
            result_q  <= result_d;
            base_q    <= base_d;
            acc_r_q   <= acc_r_d;
            acc_b_q   <= acc_b_d;
            bit_idx_q <= bit_idx_d;
            iter_q    <= iter_d;
            c_q       <= c_d;
            err_q     <= err_d;
        end
    end

    logic             mul_bit;
    logic [WIDTH:0]   r_next;
    logic [WIDTH:0]   b_next;
    logic [WIDTH-1:0] e_shift;
    logic             last_iter;

    // Both products scan the bits of base MSB-first, so one bit index drives
    // the R = result*base and B = base*base multipliers together.
    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        n_d       = n_q;
        result_d  = result_q;
        base_d    = base_q;
        acc_r_d   = acc_r_q;
        acc_b_d   = acc_b_q;
        bit_idx_d = bit_idx_q;
        iter_d    = iter_q;
        c_d       = c_q;
        err_d     = err_q;

        mul_bit   = base_q[bit_idx_q];
        r_next    = mod_mul_step(acc_r_q, result_q, mul_bit, n_q);
        b_next    = mod_mul_step(acc_b_q, base_q, mul_bit, n_q);
        e_shift   = e_q >> 1;
        last_iter = EARLY_EXIT ? (e_shift == '0) : (iter_q == IW'(WIDTH - 1));

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    e_d       = bus.exp_key;
                    n_d       = bus.n;
                    base_d    = bus.message;
                    result_d  = WIDTH'(1);
                    iter_d    = '0;
                    acc_r_d   = '0;
                    acc_b_d   = '0;
                    bit_idx_d = JW'(WIDTH - 1);
                    if ((bus.n < WIDTH'(2)) || (bus.message >= bus.n)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        c_d     = '0;
                    end else if (EARLY_EXIT && (bus.exp_key == '0)) begin
                        state_d = DONE;
                        c_d     = WIDTH'(1);
                    end else begin
                        state_d = MUL;
                    end
                end
            end

            MUL: begin
                acc_r_d = r_next;
                acc_b_d = b_next;
                if (bit_idx_q == '0) begin
                    state_d = STEP;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
            end

            STEP: begin
                if (e_q[0]) result_d = acc_r_q[WIDTH-1:0];
                base_d    = acc_b_q[WIDTH-1:0];
                e_d       = e_shift;
                iter_d    = iter_q + 1'b1;
                acc_r_d   = '0;
                acc_b_d   = '0;
                bit_idx_d = JW'(WIDTH - 1);
                if (last_iter) begin
                    state_d = DONE;
                    // c must see this cycle's result update, not result_q
                    c_d     = e_q[0] ? acc_r_q[WIDTH-1:0] : result_q;
                end else begin
                    state_d = MUL;
                end
            end

            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.c    = c_q;
    assign bus.busy = (state_q == MUL) || (state_q == STEP);
    assign bus.done = (state_q == DONE);
    assign bus.err  = err_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core
// Directed bench for rsa_modexp_core: one 128-bit and one 16-bit instance.
// Expected results and latencies are hand-computed; latency expectations
// follow RSA_CONST_TIME_EN when it is defined for the build.
module tb_rsa_modexp_core;

`ifdef RSA_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rsa_modexp_core_if #(.WIDTH(16))  ifs ();
    rsa_modexp_core_if #(.WIDTH(128)) ifb ();

    rsa_modexp_core #(.WIDTH(16)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs.slave)
    );

    rsa_modexp_core #(.WIDTH(128)) dut_big (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    // Done cycle counted from the acceptance edge, given the exponent bit length.
    function automatic int expLat(input int w, input int bitLen);
        return CONST_TIME ? (w * (w + 1) + 1) : (bitLen * (w + 1) + 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks = checks + 1;
        assert (observed === expected) passed = passed + 1;
        else begin
            failures = failures + 1;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Presents one request for exactly one clock edge; returns just after it.
    task automatic applyStimulus(input bit big, input logic [127:0] m,
                                 input logic [127:0] e, input logic [127:0] nn);
        @(negedge clk);
        if (big) begin
            ifb.message = m;
            ifb.exp_key = e;
            ifb.n       = nn;
            ifb.start   = 1'b1;
        end else begin
            ifs.message = m[15:0];
            ifs.exp_key = e[15:0];
            ifs.n       = nn[15:0];
            ifs.start   = 1'b1;
        end
        @(posedge clk);
        #1;
        ifs.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    task automatic waitDone(input bit big, input int maxCycles, output int lat,
                            output logic [127:0] cObs, output logic errObs,
                            output logic busyFirst);
        lat       = -1;
        cObs      = '0;
        errObs    = 1'b0;
        busyFirst = 1'b0;
        for (int k = 1; k <= maxCycles; k++) begin
            @(negedge clk);
            if (k == 1) busyFirst = big ? ifb.busy : ifs.busy;
            if ((big ? ifb.done : ifs.done) === 1'b1) begin
                lat = k;
                if (big) cObs = ifb.c;
                else     cObs = 128'(ifs.c);
                errObs = big ? ifb.err : ifs.err;
                break;
            end
        end
    endtask

    task automatic runCase(input string tag, input bit big, input logic [127:0] m,
                           input logic [127:0] e, input logic [127:0] nn,
                           input logic [127:0] expC, input logic expErr,
                           input int expLatency, input logic expBusy);
        int           lat;
        logic [127:0] cObs;
        logic         errObs;
        logic         busyFirst;
        applyStimulus(big, m, e, nn);
        waitDone(big, expLatency + 20, lat, cObs, errObs, busyFirst);
        checkOutput({tag, ".c"}, cObs, expC);
        checkOutput({tag, ".err"}, 128'(errObs), 128'(expErr));
        checkOutput({tag, ".latency"}, 128'(lat), 128'(expLatency));
        checkOutput({tag, ".busyFirst"}, 128'(busyFirst), 128'(expBusy));
    endtask

    initial begin
        int           lat;
        int           donePulses;
        logic [127:0] cObs;
        logic         errObs;
        logic         busyFirst;

        reset = 1'b1;
        ifs.start = 1'b0; ifs.message = '0; ifs.exp_key = '0; ifs.n = '0;
        ifb.start = 1'b0; ifb.message = '0; ifb.exp_key = '0; ifb.n = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst.small.c",    128'(ifs.c),    128'd0);
        checkOutput("rst.small.busy", 128'(ifs.busy), 128'd0);
        checkOutput("rst.small.done", 128'(ifs.done), 128'd0);
        checkOutput("rst.small.err",  128'(ifs.err),  128'd0);
        checkOutput("rst.big.c",      ifb.c,          128'd0);
        checkOutput("rst.big.busy",   128'(ifb.busy), 128'd0);
        checkOutput("rst.big.done",   128'(ifb.done), 128'd0);
        checkOutput("rst.big.err",    128'(ifb.err),  128'd0);
        reset = 1'b0;

        $display("[TB] 128-bit 920^17 mod 2773");
        runCase("big_948", 1'b1, 128'd920, 128'd17, 128'd2773, 128'd948, 1'b0, expLat(128, 5), 1'b1);

        $display("[TB] 16-bit directed vectors");
        runCase("s_445",  1'b0, 128'd4,  128'd13, 128'd497,  128'd445, 1'b0, expLat(16, 4), 1'b1);
        runCase("s_e0",   1'b0, 128'd5,  128'd0,  128'd13,   128'd1,   1'b0, expLat(16, 0), CONST_TIME);
        runCase("s_mgen", 1'b0, 128'd13, 128'd3,  128'd13,   128'd0,   1'b1, 1,             1'b0);
        runCase("s_24",   1'b0, 128'd2,  128'd10, 128'd1000, 128'd24,  1'b0, expLat(16, 4), 1'b1);
        runCase("s_n1",   1'b0, 128'd0,  128'd5,  128'd1,    128'd0,   1'b1, 1,             1'b0);
        runCase("s_m0",   1'b0, 128'd0,  128'd5,  128'd13,   128'd0,   1'b0, expLat(16, 3), 1'b1);

        $display("[TB] second start while busy");
        applyStimulus(1'b0, 128'd4, 128'd13, 128'd497);
        repeat (5) @(negedge clk);
        ifs.message = 16'd5; ifs.exp_key = 16'd3; ifs.n = 16'd13; ifs.start = 1'b1;
        @(negedge clk);
        ifs.start = 1'b0;
        waitDone(1'b0, expLat(16, 4) + 20, lat, cObs, errObs, busyFirst);
        checkOutput("restart.c",       cObs,         128'd445);
        checkOutput("restart.err",     128'(errObs), 128'd0);
        checkOutput("restart.latency", 128'(lat),    128'(expLat(16, 4) - 6));

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 128'd4, 128'd13, 128'd497);
        repeat (30) @(negedge clk);
        checkOutput("rstmid.busyBefore", 128'(ifs.busy), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstmid.c",    128'(ifs.c),    128'd0);
        checkOutput("rstmid.busy", 128'(ifs.busy), 128'd0);
        checkOutput("rstmid.done", 128'(ifs.done), 128'd0);
        checkOutput("rstmid.err",  128'(ifs.err),  128'd0);
        reset = 1'b0;
        donePulses = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ifs.done !== 1'b0) donePulses++;
        end
        checkOutput("rstmid.noDone", 128'(donePulses), 128'd0);
        runCase("s_fresh", 1'b0, 128'd4, 128'd13, 128'd497, 128'd445, 1'b0, expLat(16, 4), 1'b1);

        $display("[TB] start held high");
        @(negedge clk);
        ifs.message = 16'd5; ifs.exp_key = 16'd3; ifs.n = 16'd13; ifs.start = 1'b1;
        waitDone(1'b0, expLat(16, 2) + 20, lat, cObs, errObs, busyFirst);
        checkOutput("held1.c",       cObs,         128'd8);
        checkOutput("held1.err",     128'(errObs), 128'd0);
        checkOutput("held1.latency", 128'(lat),    128'(expLat(16, 2)));
        checkOutput("held1.busyInDone", 128'(ifs.busy), 128'd0);
        @(negedge clk);
        checkOutput("held1.doneWidth", 128'(ifs.done), 128'd0);
        checkOutput("held1.idleBusy",  128'(ifs.busy), 128'd0);
        @(negedge clk);
        checkOutput("held2.busyAgain", 128'(ifs.busy), 128'd1);
        waitDone(1'b0, expLat(16, 2) + 20, lat, cObs, errObs, busyFirst);
        ifs.start = 1'b0;
        checkOutput("held2.c",       cObs,      128'd8);
        checkOutput("held2.latency", 128'(lat), 128'(expLat(16, 2) - 1));
        @(negedge clk);
        checkOutput("held2.doneWidth", 128'(ifs.done), 128'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
